// File: rtl/io_slot_decoder.sv
// I/O bus decoder: splits the CPU I/O address into slot/register, runs a
// req/ack handshake with a one-hot slot select, and reports bus errors.
module io_slot_decoder #(
  parameter int SLOT_BITS  = 3,
  parameter int REG_BITS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter logic [2**SLOT_BITS-1:0] RESV_MASK = {{(2**SLOT_BITS-2){1'b1}}, 2'b00},
  localparam int NUM_SLOTS = 2**SLOT_BITS,
  localparam int AW        = SLOT_BITS + REG_BITS
) (
  input  logic                            Clock,
  input  logic                            Reset_N,
  input  logic                            Req_i,
  input  logic                            Wr_i,
  input  logic [AW-1:0]                   Addr_i,
  input  logic [DATA_WIDTH-1:0]           WrData_i,
  output logic                            Ready_o,
  output logic                            Err_o,
  output logic [DATA_WIDTH-1:0]           RdData_o,
  output logic [NUM_SLOTS-1:0]            SlotSel_o,
  output logic                            SlotWr_o,
  output logic [REG_BITS-1:0]             SlotRegAddr_o,
  output logic [DATA_WIDTH-1:0]           SlotWrData_o,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] SlotRdData_i,
  input  logic [NUM_SLOTS-1:0]            SlotAck_i,
  input  logic                            ErrClr_i,
  output logic                            ErrValid_o,
  output logic [AW-1:0]                   ErrAddr_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state;
  logic [SLOT_BITS-1:0]   slot_q;
  logic [CW-1:0]          cnt;

  logic [SLOT_BITS-1:0]   req_slot;
  logic                   req_resv;
  logic                   sel_ack;
  logic                   timeout_hit;
  logic [DATA_WIDTH-1:0]  sel_rd;
  logic                   err_evt;
  logic [AW-1:0]          err_evt_addr;

  assign req_slot    = Addr_i[AW-1:REG_BITS];
  assign req_resv    = RESV_MASK[req_slot];
  assign sel_ack     = SlotAck_i[slot_q];
  assign sel_rd      = SlotRdData_i[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH];
  assign timeout_hit = (cnt == CNT_LAST);

  // Ack has priority over timeout, so a timeout is only an error without ack.
  always_comb begin
    err_evt      = 1'b0;
    err_evt_addr = {slot_q, SlotRegAddr_o};
    if (state == IDLE && Req_i && req_resv) begin
      err_evt      = 1'b1;
      err_evt_addr = Addr_i;
    end else if (state == ACCESS && !sel_ack && timeout_hit) begin
      err_evt      = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state         <= IDLE;
      slot_q        <= '0;
      cnt           <= '0;
      Ready_o       <= 1'b0;
      Err_o         <= 1'b0;
      RdData_o      <= '0;
      SlotSel_o     <= '0;
      SlotWr_o      <= 1'b0;
      SlotRegAddr_o <= '0;
      SlotWrData_o  <= '0;
      ErrValid_o    <= 1'b0;
      ErrAddr_o     <= '0;
    end else begin
      Ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (Req_i) begin
            slot_q        <= req_slot;
            SlotRegAddr_o <= Addr_i[REG_BITS-1:0];
            SlotWrData_o  <= WrData_i;
            if (req_resv) begin
              state    <= DONE;
              Ready_o  <= 1'b1;
              Err_o    <= 1'b1;
              RdData_o <= '0;
            end else begin
              state     <= ACCESS;
              SlotSel_o <= NUM_SLOTS'(1) << req_slot;
              SlotWr_o  <= Wr_i;
              cnt       <= '0;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            RdData_o  <= SlotWr_o ? '0 : sel_rd;
            Err_o     <= 1'b0;
            SlotSel_o <= '0;
            SlotWr_o  <= 1'b0;
            Ready_o   <= 1'b1;
            state     <= DONE;
          end else if (timeout_hit) begin
            RdData_o  <= '0;
            Err_o     <= 1'b1;
            SlotSel_o <= '0;
            SlotWr_o  <= 1'b0;
            Ready_o   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // First error since the last clear is held; a same-cycle clear loses.
      if (err_evt && (!ErrValid_o || ErrClr_i)) begin
        ErrValid_o <= 1'b1;
        ErrAddr_o  <= err_evt_addr;
      end else if (ErrClr_i) begin
        ErrValid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_slot_decoder.sv
// Scoreboard bench for io_slot_decoder: directed plan cases plus random accesses.
module tb_io_slot_decoder;

  localparam int TO = 15;

  logic         Clock = 1'b0;
  logic         Reset_N, Req_i, Wr_i, ErrClr_i;
  logic [6:0]   Addr_i;
  logic [31:0]  WrData_i;
  logic         Ready_o, Err_o, SlotWr_o, ErrValid_o;
  logic [31:0]  RdData_o, SlotWrData_o;
  logic [7:0]   SlotSel_o;
  logic [7:0]   SlotAck_i = 8'h00;
  logic [3:0]   SlotRegAddr_o;
  logic [255:0] SlotRdData_i;
  logic [6:0]   ErrAddr_o;

  always #5 Clock = ~Clock;

  io_slot_decoder #(.TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset_N(Reset_N), .Req_i(Req_i), .Wr_i(Wr_i),
    .Addr_i(Addr_i), .WrData_i(WrData_i), .Ready_o(Ready_o), .Err_o(Err_o),
    .RdData_o(RdData_o), .SlotSel_o(SlotSel_o), .SlotWr_o(SlotWr_o),
    .SlotRegAddr_o(SlotRegAddr_o), .SlotWrData_o(SlotWrData_o),
    .SlotRdData_i(SlotRdData_i), .SlotAck_i(SlotAck_i), .ErrClr_i(ErrClr_i),
    .ErrValid_o(ErrValid_o), .ErrAddr_o(ErrAddr_o)
  );

  typedef struct {
    logic        err;
    logic [31:0] rd;
    logic        ev;
    logic [6:0]  ea;
    logic [3:0]  rg;
    logic [31:0] wd;
    logic [7:0]  sel;
    logic        wr;
    int          sel_cyc;
    int          rdy_cyc;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          cur_delay = 0;
  bit          rst_chk = 0, hang = 0, end_chk = 0, aborted = 0;
  logic [7:0]  sel_seen = 8'h00;
  logic        wr_seen = 1'b0;
  int          sel_cnt = 0;
  logic        m_ev = 1'b0;
  logic [6:0]  m_ea = 7'h00;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor + slot responder: checks completions, then models the peripherals.
  always @(negedge Clock) begin
    exp_t e;
    if (rst_chk) begin
      chk("rst_ready", Ready_o, 0);        chk("rst_err", Err_o, 0);
      chk("rst_rddata", RdData_o, 0);      chk("rst_slotsel", SlotSel_o, 0);
      chk("rst_slotwr", SlotWr_o, 0);      chk("rst_regaddr", SlotRegAddr_o, 0);
      chk("rst_wrdata", SlotWrData_o, 0);  chk("rst_errvalid", ErrValid_o, 0);
      chk("rst_erraddr", ErrAddr_o, 0);
    end
    if (hang) begin
      tests++; fails++;
      $display("FAIL ready_timeout: Ready_o still 0 after 100 cycles, required a completion");
    end
    if (end_chk) chk("queue_drained", q.size(), 0);
    if (Ready_o) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ready: Ready_o=1 with no access pending, required 0");
      end else begin
        e = q.pop_front();
        chk("err", Err_o, e.err);
        chk("rddata", RdData_o, e.rd);
        chk("errvalid", ErrValid_o, e.ev);
        chk("erraddr", ErrAddr_o, e.ea);
        chk("regaddr", SlotRegAddr_o, e.rg);
        chk("wrdata", SlotWrData_o, e.wd);
        chk("slotsel", sel_seen, e.sel);
        chk("slotwr", wr_seen, e.wr);
        chk("sel_cycles", sel_cnt, e.sel_cyc);
        chk("ready_cycle", cyc, e.rdy_cyc);
      end
      sel_cnt = 0; sel_seen = 8'h00; wr_seen = 1'b0;
    end
    if (!Reset_N) begin
      sel_cnt = 0; sel_seen = 8'h00; wr_seen = 1'b0;
    end
    if (SlotSel_o != 8'h00) begin
      if (sel_cnt == 0) begin
        sel_seen = SlotSel_o;
        wr_seen  = SlotWr_o;
      end
      sel_cnt++;
      SlotAck_i = ((sel_cnt == cur_delay) ? SlotSel_o : 8'h00) | (8'($urandom) & ~SlotSel_o);
    end else begin
      SlotAck_i = 8'($urandom);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clock); #1;
    end
  endtask

  task automatic clr_pulse();
    Req_i = 1'b0; ErrClr_i = 1'b1;
    step(1);
    ErrClr_i = 1'b0;
    m_ev = 1'b0;
  endtask

  // delay = select cycle in which the slot acks; above TO means it never acks.
  task automatic issue(input logic [6:0] addr, input logic wr, input logic [31:0] wd,
                       input int delay, input bit b2b, input bit clr_with,
                       input bit fix, input logic [31:0] fixd);
    exp_t e;
    int slot, lat;
    bit resv, tout, ok;
    logic [31:0] sd[8];
    slot = int'(addr[6:4]);
    for (int i = 0; i < 8; i++) begin
      sd[i] = $urandom;
      if (fix && i == slot) sd[i] = fixd;
      SlotRdData_i[i*32 +: 32] = sd[i];
    end
    Addr_i = addr; Wr_i = wr; WrData_i = wd; cur_delay = delay;
    Req_i = 1'b1; ErrClr_i = clr_with;

    resv = !(slot == 0 || slot == 1);
    tout = !resv && (delay > TO);
    e.rg = addr[3:0];
    e.wd = wd;
    if (resv) begin
      e.err = 1; e.rd = 0; e.sel = 0; e.wr = 0; e.sel_cyc = 0; lat = 1;
    end else begin
      e.sel = 8'(1) << slot; e.wr = wr;
      e.err = tout;
      e.rd  = (tout || wr) ? 32'h0 : sd[slot];
      e.sel_cyc = tout ? TO : delay;
      lat = e.sel_cyc + 1;
    end
    if (resv) begin
      if (!m_ev || clr_with) begin m_ev = 1; m_ea = addr; end
    end else if (clr_with) begin
      m_ev = 0;
    end
    if (tout && !m_ev) begin m_ev = 1; m_ea = addr; end
    e.ev = m_ev; e.ea = m_ea;
    e.rdy_cyc = b2b ? cyc + 1 + lat : cyc + lat;
    q.push_back(e);

    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step(1);
      ErrClr_i = 1'b0;
      if (Ready_o) ok = 1;
    end
    if (!ok) begin
      hang = 1; step(1); hang = 0;
      aborted = 1;
    end
  endtask

  initial begin
    bit b2b, clrw;
    Reset_N = 1'b0; Req_i = 1'b0; Wr_i = 1'b0; ErrClr_i = 1'b0;
    Addr_i = '0; WrData_i = '0; SlotRdData_i = '0;
    rst_chk = 1;
    step(2);
    rst_chk = 0; Reset_N = 1'b1;
    step(2);

    issue(7'h01, 0, 32'h0, 1, 0, 0, 1, 32'hA5A5_0001); Req_i = 0; step(1);
    issue(7'h10, 1, 32'h0000_00FF, 4, 0, 0, 0, 0);    Req_i = 0; step(1);
    issue(7'h25, 0, 32'h0, 1, 0, 0, 0, 0);             Req_i = 0; step(1);
    issue(7'h12, 0, 32'h0, TO + 5, 0, 0, 0, 0);        Req_i = 0; step(1);
    issue(7'h13, 0, 32'h0, TO, 0, 0, 0, 0);            Req_i = 0; step(1);
    clr_pulse();
    issue(7'h30, 0, 32'h0, 1, 0, 0, 0, 0);             Req_i = 0; step(1);
    issue(7'h41, 0, 32'h0, 1, 0, 0, 0, 0);             Req_i = 0; step(1);
    clr_pulse();
    issue(7'h30, 0, 32'h0, 1, 0, 0, 0, 0);             Req_i = 0; step(1);
    issue(7'h41, 0, 32'h0, 1, 0, 1, 0, 0);             Req_i = 0; step(1);
    issue(7'h01, 0, 32'h0, 1, 0, 0, 0, 0);
    issue(7'h1A, 1, 32'h1234_5678, 2, 1, 0, 0, 0);
    issue(7'h50, 0, 32'h0, 1, 1, 0, 0, 0);
    issue(7'h00, 0, 32'h0, 1, 1, 0, 0, 0);             Req_i = 0; step(1);

    Addr_i = 7'h12; Wr_i = 1'b1; WrData_i = $urandom; cur_delay = TO + 5; Req_i = 1'b1;
    step(5);
    Reset_N = 1'b0; Req_i = 1'b0; rst_chk = 1;
    step(1);
    rst_chk = 0; Reset_N = 1'b1; m_ev = 0; m_ea = 0;
    step(4);
    issue(7'h07, 0, 32'h0, 2, 0, 0, 0, 0);

    for (int n = 0; n < 200 && !aborted; n++) begin
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        Req_i = 0;
        step($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) clr_pulse();
      end
      clrw = !b2b && ($urandom_range(0, 7) == 0);
      issue(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(1, TO + 3), b2b, clrw, 0, 0);
    end
    Req_i = 0;
    step(3);
    end_chk = 1;
    step(1);
    end_chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_slot_decoder.md
# io_slot_decoder

Parametrised I/O bus decoder between the CPU data port and the peripheral slots (EIC at slot 0, BKD at slot 1, remaining slots reserved by default). Splits each I/O address into a slot index and a register offset, drives a one-hot slot select with a request/acknowledge handshake, and enforces a bounded access time with a timeout. Reports accesses to reserved slots and timed-out accesses as bus errors, with a sticky error-address capture register.

## Interface
Parameters:
- SLOT_BITS, 3, slot index width; NUM_SLOTS = 2**SLOT_BITS
- REG_BITS, 4, register offset width within a slot
- DATA_WIDTH, 32, data bus width
- TIMEOUT, 15, maximum cycles a slot select stays asserted without ack; legal range is TIMEOUT >= 1
- RESV_MASK, NUM_SLOTS'b1111_1100, bit i = 1 marks slot i reserved; default reserves slots 2..7

Ports (AW = SLOT_BITS+REG_BITS):
- Clock  in  1  sole clock, rising edge
- Reset_N  in  1  synchronous, active-low reset
- Req_i  in  1  CPU access request; held high until Ready_o
- Wr_i  in  1  1 = write, 0 = read; sampled with Req_i
- Addr_i  in  AW  {slot, reg}; slot = Addr_i[AW-1:REG_BITS]
- WrData_i  in  DATA_WIDTH  write data
- Ready_o  out  1  one-cycle access completion pulse
- Err_o  out  1  valid with Ready_o; 1 = bus error
- RdData_o  out  DATA_WIDTH  read data, valid with Ready_o
- SlotSel_o  out  NUM_SLOTS  one-hot slot select
- SlotWr_o  out  1  write strobe qualifier for the selected slot
- SlotRegAddr_o  out  REG_BITS  latched register offset
- SlotWrData_o  out  DATA_WIDTH  latched write data
- SlotRdData_i  in  NUM_SLOTS*DATA_WIDTH  per-slot read data; slot i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- SlotAck_i  in  NUM_SLOTS  per-slot acknowledge
- ErrClr_i  in  1  clears the sticky error capture
- ErrValid_o  out  1  sticky: an error has occurred since the last clear
- ErrAddr_o  out  AW  address of the first error since the last clear

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on Req_i = 1, latch Addr_i, Wr_i and WrData_i.
  - Reserved slot (RESV_MASK[slot] = 1): go to DONE with error; no SlotSel bit is asserted.
  - Otherwise: go to ACCESS, assert SlotSel_o[slot], drive SlotWr_o = Wr_i, and clear the timeout counter.
- ACCESS:
  - SlotAck_i[slot] = 1: capture SlotRdData_i[slot] into RdData_o (capture 0 on a write), clear Err, drop SlotSel_o, go to DONE.
  - Else, if the counter has reached TIMEOUT-1: timeout; RdData_o = 0, Err = 1, drop SlotSel_o, go to DONE.
  - Else: increment the counter. Counter width is $clog2(TIMEOUT+1).
  - Ack bits of unselected slots are ignored.
- DONE: Ready_o = 1 for this cycle only, with Err_o and RdData_o valid; then return to IDLE.
- Req_i is ignored in ACCESS and DONE. A new access is sampled only in IDLE.
- Error capture: on any error (reserved slot or timeout), if ErrValid_o = 0, set ErrValid_o and load ErrAddr_o. A later error does not overwrite a held address.
  - ErrClr_i = 1 clears ErrValid_o.
  - If an error and ErrClr_i occur in the same cycle, the error wins: ErrValid_o = 1 and the new address is loaded.
- RdData_o, Err_o and the SlotReg/SlotWrData latches hold their values outside DONE; they change only on the next access.

## Timing
- All outputs are registered.
- Reset values: Ready_o 0, Err_o 0, RdData_o 0, SlotSel_o 0, SlotWr_o 0, SlotRegAddr_o 0, SlotWrData_o 0, ErrValid_o 0, ErrAddr_o 0, FSM IDLE, counter 0.
- Reset mid-access: SlotSel_o and Ready_o are 0 after the reset edge; no Ready_o pulse is issued for the aborted access.
- Mapped slot with ack in the first ACCESS cycle: Req_i sampled at edge 0, SlotSel_o high in cycle 1, Ready_o high in cycle 2.
- Each cycle of ack delay adds one cycle of latency.
- Reserved slot: Req_i sampled at edge 0, Ready_o with Err_o = 1 in cycle 1; SlotSel_o stays 0 throughout.
- Timeout: SlotSel_o is high for exactly TIMEOUT cycles, then Ready_o with Err_o = 1 in the next cycle.
- Ack in the last (TIMEOUT-th) select cycle: the ack wins; Err_o = 0 and data is captured.
- Back-to-back accesses: with Req_i held high, the minimum period is 3 cycles for a mapped slot and 2 cycles for a reserved slot.

## Test plan
- Read at slot 0, reg 1 (Addr 0x01); slot 0 acks in its first select cycle with data 0xA5A5_0001 -> SlotSel_o = 0x01, SlotRegAddr_o = 1, SlotWr_o = 0; Ready_o in cycle 2 with RdData_o = 0xA5A5_0001, Err_o = 0.
- Write 0x0000_00FF to slot 1, reg 0 (Addr 0x10); ack after 3 cycles -> SlotSel_o = 0x02, SlotWr_o = 1, SlotWrData_o = 0xFF; Ready_o in cycle 5 with RdData_o = 0, Err_o = 0.
- Read at Addr 0x25 (reserved slot 2) -> SlotSel_o never asserted; Ready_o in cycle 1 with Err_o = 1; ErrValid_o = 1, ErrAddr_o = 0x25.
- Slot 1 never acks, TIMEOUT = 15 -> SlotSel_o = 0x02 for exactly 15 cycles; Ready_o with Err_o = 1 in the next cycle. Repeat with the ack in the 15th select cycle -> Err_o = 0.
- Two errors, first at Addr 0x30 then at Addr 0x41 -> ErrAddr_o stays 0x30. Assert ErrClr_i in the same cycle as the second error -> ErrValid_o = 1, ErrAddr_o = 0x41.
- Assert Reset_N = 0 mid-ACCESS -> all outputs at reset values after the edge, no Ready_o pulse; a fresh access after reset completes normally.
